// File: rtl/elevator_queue_ctrl.sv
// elevator_queue_ctrl: FIFO of requested levels plus IDLE/MOVE/DOOR car sequencer
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   pressed_en/lvl  one-cycle button strobe and its level
//   queue, tail     request FIFO (entry 0 is the head) and its occupancy
//   cur_lvl         level the car is at or last passed
//   moving_up/down  travel direction flags
//   door_open       door held open
//   drop            one-cycle pulse when a new press finds the queue full
module elevator_queue_ctrl #(
   parameter int DEPTH       = 4,
   parameter int LVL_W       = 2,
   parameter int MOVE_CYCLES = 8,
   parameter int DOOR_CYCLES = 16
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       pressed_en,
   input  logic [LVL_W-1:0]           pressed_lvl,
   output logic [DEPTH*LVL_W-1:0]     queue,
   output logic [$clog2(DEPTH):0]     tail,
   output logic [LVL_W-1:0]           cur_lvl,
   output logic                       moving_up,
   output logic                       moving_down,
   output logic                       door_open,
   output logic                       drop
);
   localparam int TW = $clog2(DEPTH) + 1;
   localparam int CW = $clog2(MOVE_CYCLES > DOOR_CYCLES ? MOVE_CYCLES : DOOR_CYCLES);
   localparam logic [CW-1:0] MOVE_LOAD = CW'(MOVE_CYCLES - 1);
   localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES - 1);
   localparam logic [LVL_W-1:0] MAX_LVL = '1;
   typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [LVL_W-1:0] head, lvl_n, step;
   logic [DEPTH*LVL_W-1:0] queue_n;
   logic [TW-1:0] tail_n, widx;
   logic dir, dir_n, pop, push, want, dup, drop_n;
   assign head = queue[LVL_W-1:0];
   // Counters load N-1 and run down to 0, so each phase lasts exactly N cycles.
   assign step = dir ? (cur_lvl == MAX_LVL ? cur_lvl : cur_lvl + 1'b1)
                     : (cur_lvl == '0 ? cur_lvl : cur_lvl - 1'b1);
   always_comb begin
      dup = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (TW'(i) < tail && queue[i*LVL_W +: LVL_W] == pressed_lvl) dup = 1'b1;
   end
   // A press for the current level while idle opens the door instead of queueing.
   assign want   = pressed_en && !dup && !(state == IDLE && pressed_lvl == cur_lvl);
   assign push   = want && (tail != TW'(DEPTH) || pop);
   assign drop_n = want && tail == TW'(DEPTH) && !pop;
   assign widx   = pop ? tail - 1'b1 : tail;
   always_comb begin
      queue_n = pop ? {{LVL_W{1'b0}}, queue[DEPTH*LVL_W-1:LVL_W]} : queue;
      if (push) queue_n[widx*LVL_W +: LVL_W] = pressed_lvl;
      tail_n = tail + TW'(push) - TW'(pop);
   end
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      lvl_n   = cur_lvl;
      dir_n   = dir;
      pop     = 1'b0;
      case (state)
         IDLE:
            if (tail != '0 && head == cur_lvl) begin
               pop     = 1'b1;
               state_n = DOOR;
               cnt_n   = DOOR_LOAD;
            end else if (pressed_en && pressed_lvl == cur_lvl) begin
               state_n = DOOR;
               cnt_n   = DOOR_LOAD;
            end else if (tail != '0) begin
               state_n = MOVE;
               cnt_n   = MOVE_LOAD;
               dir_n   = head > cur_lvl;
            end
         MOVE:
            if (cnt != '0) cnt_n = cnt - 1'b1;
            else begin
               lvl_n = step;
               if (step == head) begin
                  pop     = 1'b1;
                  state_n = DOOR;
                  cnt_n   = DOOR_LOAD;
               end else cnt_n = MOVE_LOAD;
            end
         DOOR:
            if (cnt != '0) cnt_n = cnt - 1'b1;
            else state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         dir         <= 1'b0;
         queue       <= '0;
         tail        <= '0;
         cur_lvl     <= '0;
         moving_up   <= 1'b0;
         moving_down <= 1'b0;
         door_open   <= 1'b0;
         drop        <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         dir         <= dir_n;
         queue       <= queue_n;
         tail        <= tail_n;
         cur_lvl     <= lvl_n;
         moving_up   <= state_n == MOVE && dir_n;
         moving_down <= state_n == MOVE && !dir_n;
         door_open   <= state_n == DOOR;
         drop        <= drop_n;
      end
endmodule

// File: tb/tb_elevator_queue_ctrl.sv
// tb_elevator_queue_ctrl: scoreboard bench for the elevator queue controller
module tb_elevator_queue_ctrl;
   localparam int DEPTH = 4, LW = 3, MC = 8, DC = 16;
   logic clk = 1'b0, rst = 1'b1, pressed_en = 1'b0;
   logic [LW-1:0] pressed_lvl = '0;
   logic [DEPTH*LW-1:0] queue;
   logic [2:0] tail;
   logic [LW-1:0] cur_lvl;
   logic moving_up, moving_down, door_open, drop;
   int checks = 0, errors = 0;
   typedef struct packed {
      logic [11:0] q;
      logic [2:0] tail;
      logic [2:0] cur;
      logic up, dn, door, drop;
   } snap_t;
   typedef struct packed {logic [2:0] lvl; logic [2:0] tail;} door_t;
   snap_t snap_q[$];
   string snap_n[$];
   door_t door_q[$];
   int up_q[$], dn_q[$];
   logic [2:0] drop_q[$];
   int up_w = 0, dn_w = 0, door_w = 0;
   door_t door_seen;
   always #5 clk = ~clk;
   elevator_queue_ctrl #(.DEPTH(DEPTH), .LVL_W(LW), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
      .clk(clk), .rst(rst), .pressed_en(pressed_en), .pressed_lvl(pressed_lvl),
      .queue(queue), .tail(tail), .cur_lvl(cur_lvl), .moving_up(moving_up),
      .moving_down(moving_down), .door_open(door_open), .drop(drop));
   always @(negedge clk) begin
      snap_t act, e;
      string n;
      door_t de;
      int w;
      act = {queue, tail, cur_lvl, moving_up, moving_down, door_open, drop};
      while (snap_q.size() > 0) begin
         e = snap_q.pop_front();
         n = snap_n.pop_front();
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL %s: got q=%h tail=%0d cur=%0d up=%b dn=%b door=%b drop=%b, want q=%h tail=%0d cur=%0d up=%b dn=%b door=%b drop=%b",
                     n, act.q, act.tail, act.cur, act.up, act.dn, act.door, act.drop,
                     e.q, e.tail, e.cur, e.up, e.dn, e.door, e.drop);
         end
      end
      checks++;
      if ((moving_up && moving_down) || (door_open && (moving_up || moving_down))) begin
         errors++;
         $display("FAIL exclusive: got up=%b dn=%b door=%b, want at most one", moving_up, moving_down, door_open);
      end
      if (moving_up) up_w++;
      else if (up_w > 0) begin
         checks++;
         w = up_q.size() > 0 ? up_q.pop_front() : -1;
         if (w != up_w) begin
            errors++;
            $display("FAIL up run: got %0d cycles, want %0d", up_w, w);
         end
         up_w = 0;
      end
      if (moving_down) dn_w++;
      else if (dn_w > 0) begin
         checks++;
         w = dn_q.size() > 0 ? dn_q.pop_front() : -1;
         if (w != dn_w) begin
            errors++;
            $display("FAIL down run: got %0d cycles, want %0d", dn_w, w);
         end
         dn_w = 0;
      end
      if (drop) begin
         checks++;
         if (drop_q.size() == 0) begin
            errors++;
            $display("FAIL drop: got unexpected drop at tail=%0d, want none", tail);
         end else begin
            de.tail = drop_q.pop_front();
            if (tail !== de.tail) begin
               errors++;
               $display("FAIL drop tail: got %0d, want %0d", tail, de.tail);
            end
         end
      end
      if (door_open) begin
         if (door_w == 0) door_seen = {cur_lvl, tail};
         door_w++;
      end else if (door_w > 0) begin
         checks++;
         if (door_q.size() == 0) begin
            errors++;
            $display("FAIL door: got unexpected door at lvl %0d, want none", door_seen.lvl);
         end else begin
            de = door_q.pop_front();
            if (door_seen !== de || door_w != DC) begin
               errors++;
               $display("FAIL door: got lvl=%0d tail=%0d width=%0d, want lvl=%0d tail=%0d width=%0d",
                        door_seen.lvl, door_seen.tail, door_w, de.lvl, de.tail, DC);
            end
         end
         door_w = 0;
      end
   end
   task automatic press(input logic [LW-1:0] l);
      pressed_en  = 1'b1;
      pressed_lvl = l;
      @(posedge clk);
      #1;
      pressed_en  = 1'b0;
   endtask
   task automatic snap(input string n, input logic [11:0] q, input logic [2:0] t, input logic [2:0] c,
                       input logic u, input logic d, input logic o, input logic p);
      snap_q.push_back({q, t, c, u, d, o, p});
      snap_n.push_back(n);
   endtask
   task automatic expect_door(input logic [2:0] l, input logic [2:0] t);
      door_q.push_back({l, t});
   endtask
   task automatic wait_idle(input string n);
      int s = 0;
      for (int k = 0; k < 3000 && s < 3; k++) begin
         @(posedge clk);
         #1;
         s = (tail == 0 && !moving_up && !moving_down && !door_open) ? s + 1 : 0;
      end
      checks++;
      if (s < 3) begin
         errors++;
         $display("FAIL %s idle: got tail=%0d up=%b dn=%b door=%b, want idle within bound",
                  n, tail, moving_up, moving_down, door_open);
      end
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      snap("reset", 12'h000, 0, 0, 0, 0, 0, 0);
      press(2);
      snap("t1 push", 12'h002, 1, 0, 0, 0, 0, 0);
      up_q.push_back(16);
      expect_door(2, 0);
      wait_idle("t1");
      press(3); press(1); press(3); press(2);
      snap("t2 dup", 12'h08B, 3, 2, 1, 0, 0, 0);
      up_q.push_back(8); dn_q.push_back(16); up_q.push_back(8);
      expect_door(3, 2); expect_door(1, 1); expect_door(2, 0);
      wait_idle("t2");
      press(0);
      dn_q.push_back(16);
      expect_door(0, 0);
      wait_idle("t3 home");
      press(1); press(2); press(3); press(0);
      drop_q.push_back(4);
      press(5);
      snap("t3 full", 12'h0D1, 4, 0, 1, 0, 0, 1);
      repeat (4) @(posedge clk);
      #1;
      press(6);
      snap("t4 pushpop", 12'hC1A, 4, 1, 0, 0, 1, 0);
      up_q.push_back(8); up_q.push_back(8); up_q.push_back(8);
      dn_q.push_back(24); up_q.push_back(48);
      expect_door(1, 4); expect_door(2, 3); expect_door(3, 2); expect_door(0, 1); expect_door(6, 0);
      wait_idle("t4");
      press(1);
      dn_q.push_back(40);
      expect_door(1, 0);
      wait_idle("t5 go");
      press(1);
      snap("t5 same lvl", 12'h000, 0, 1, 0, 0, 1, 0);
      expect_door(1, 0);
      wait_idle("t5");
      press(3);
      up_q.push_back(2);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      snap("t6 async rst", 12'h000, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      snap("t6 after rst", 12'h000, 0, 0, 0, 0, 0, 0);
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (snap_q.size() || door_q.size() || up_q.size() || dn_q.size() || drop_q.size()) begin
         errors++;
         $display("FAIL leftover: got snap=%0d door=%0d up=%0d dn=%0d drop=%0d pending, want 0",
                  snap_q.size(), door_q.size(), up_q.size(), dn_q.size(), drop_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
